// File: rtl/ring_node.sv
// ring_node: ring stop that ejects local packets, forwards others and injects from a FIFO
module ring_node #(
   parameter logic [1:0] ID    = 2'd0,
   parameter int         DW    = 16,
   parameter int         DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DW+4:0]           tx,
   output logic [DW+4:0]           rx,
   input  logic [DW+4:0]           ring_in,
   output logic [DW+4:0]           ring_out,
   output logic [$clog2(DEPTH):0]  fifo_cnt,
   output logic [7:0]              drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
   logic [DW+4:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic [7:0]    r_drop;
   logic [DW+4:0] r_rx, r_ro;
   logic [DW+4:0] w_head, w_rx_nxt, w_ro_nxt;
   logic          w_eject, w_fwd, w_empty, w_full, w_head_lb, w_pop, w_push, w_drop;
   // slot arbitration: forward wins, eject frees the slot, loopback yields to eject
   always_comb begin
      w_head    = r_mem[r_rp];
      w_eject   = ring_in[DW+4] && ring_in[DW+3:DW+2] == ID;
      w_fwd     = ring_in[DW+4] && !w_eject;
      w_empty   = r_cnt == '0;
      w_full    = r_cnt == L_FULL;
      w_head_lb = w_head[DW+3:DW+2] == ID;
      w_pop     = !w_fwd && !w_empty && (!w_head_lb || !w_eject);
      w_push    = tx[DW+4] && (!w_full || w_pop);
      w_drop    = tx[DW+4] && w_full && !w_pop;
      w_ro_nxt  = w_fwd ? ring_in : (w_pop && !w_head_lb) ? w_head : '0;
      w_rx_nxt  = w_eject ? ring_in : (w_pop && w_head_lb) ? w_head : '0;
   end
   // registered ports, FIFO pointers, occupancy and saturating drop counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx   <= '0;
         r_ro   <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_drop <= '0;
      end else begin
         r_rx  <= w_rx_nxt;
         r_ro  <= w_ro_nxt;
         r_wp  <= w_push ? r_wp + AW'(1) : r_wp;
         r_rp  <= w_pop ? r_rp + AW'(1) : r_rp;
         r_cnt <= (w_push && !w_pop) ? r_cnt + (AW+1)'(1) :
                  (w_pop && !w_push) ? r_cnt - (AW+1)'(1) : r_cnt;
         r_drop <= (w_drop && r_drop != 8'hFF) ? r_drop + 8'd1 : r_drop;
      end
   end
   // FIFO storage needs no reset: the head is only consumed when occupancy is non-zero
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= tx;
   end
   assign rx       = r_rx;
   assign ring_out = r_ro;
   assign fifo_cnt = r_cnt;
   assign drop_cnt = r_drop;
endmodule

// File: tb/tb_ring_node.sv
// tb_ring_node: random and directed checks of ring_node against a queue-based model
module tb_ring_node;
   localparam logic [1:0] ID = 2'd1;
   localparam int DW = 16;
   localparam int DEPTH = 4;
   localparam int PW = DW + 5;
   logic clk = 0;
   logic rst = 1;
   logic [PW-1:0] tx = '0, ring_in = '0;
   logic [PW-1:0] rx, ring_out;
   logic [2:0] fifo_cnt;
   logic [7:0] drop_cnt;
   int vectors = 0, miscompares = 0;
   bit chk_en = 0;
   logic [PW-1:0] q[$];
   logic [PW-1:0] e_rx = '0, e_ro = '0;
   int e_drop = 0;
   ring_node #(.ID(ID), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .tx(tx), .rx(rx), .ring_in(ring_in),
      .ring_out(ring_out), .fifo_cnt(fifo_cnt), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   function automatic logic [PW-1:0] pk(input logic [1:0] d, input logic [1:0] s, input logic [15:0] v);
      return {1'b1, d, s, v};
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_clear();
      q.delete();
      e_rx = '0;
      e_ro = '0;
      e_drop = 0;
   endtask
   // one clock of the reference: ring first, then pop the queue head, then append tx
   task automatic model_step();
      logic ej, fw;
      ej = ring_in[PW-1] && ring_in[PW-2 -: 2] == ID;
      fw = ring_in[PW-1] && !ej;
      e_ro = fw ? ring_in : '0;
      e_rx = ej ? ring_in : '0;
      if (!fw && q.size() > 0) begin
         if (q[0][PW-2 -: 2] != ID) e_ro = q.pop_front();
         else if (!ej) e_rx = q.pop_front();
      end
      if (tx[PW-1]) begin
         if (q.size() < DEPTH) q.push_back(tx);
         else if (e_drop < 255) e_drop++;
      end
   endtask
   task automatic step(input logic [PW-1:0] t, input logic [PW-1:0] r);
      tx = t;
      ring_in = r;
      @(posedge clk);
      model_step();
      #1;
   endtask
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rx", 32'(rx), 32'(e_rx));
         chk("ring_out", 32'(ring_out), 32'(e_ro));
         chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
         chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
      end
   end
   initial begin
      logic [31:0] a, b;
      int p;
      #1 rst = 0;
      model_clear();
      chk_en = 1;
      for (int i = 0; i < 3; i++) begin
         tx = pk(2'd2, 2'd0, 16'h5555);
         ring_in = pk(2'd2, 2'd3, 16'h7777);
         @(posedge clk);
         #1;
         chk("reset_ro", 32'(ring_out), 0);
         chk("reset_rx", 32'(rx), 0);
         chk("reset_cnt", 32'(fifo_cnt), 0);
      end
      rst = 1;
      step('0, pk(2'd2, 2'd0, 16'h1234));
      chk("first_fwd", 32'(ring_out), 32'(pk(2'd2, 2'd0, 16'h1234)));
      step('0, '0);
      step(pk(2'd3, 2'd1, 16'hBEEF), '0);
      step('0, pk(2'd1, 2'd2, 16'h00AA));
      chk("eject_rx", 32'(rx), 32'(pk(2'd1, 2'd2, 16'h00AA)));
      chk("inject_ro", 32'(ring_out), 32'(pk(2'd3, 2'd1, 16'hBEEF)));
      step('0, '0);
      for (int i = 0; i < 5; i++)
         step(i < 3 ? pk(2'd0, 2'd1, 16'(16'hA0 + i)) : '0, pk(2'd2, 2'd3, 16'(16'h100 + i)));
      chk("fwd_cnt", 32'(fifo_cnt), 3);
      for (int i = 0; i < 3; i++) begin
         step('0, '0);
         chk("fwd_order", 32'(ring_out), 32'(pk(2'd0, 2'd1, 16'(16'hA0 + i))));
      end
      step('0, '0);
      for (int i = 0; i < 6; i++) step(pk(2'd3, 2'd1, 16'(16'hC0 + i)), pk(2'd0, 2'd2, 16'h0F0F));
      chk("ovf_cnt", 32'(fifo_cnt), 4);
      chk("ovf_drop", 32'(drop_cnt), 2);
      step(pk(2'd3, 2'd1, 16'hC9C9), '0);
      chk("full_pushpop_cnt", 32'(fifo_cnt), 4);
      chk("full_pushpop_drop", 32'(drop_cnt), 2);
      for (int i = 0; i < 6; i++) step('0, '0);
      step(pk(2'd1, 2'd0, 16'h0C0C), '0);
      step('0, pk(2'd1, 2'd2, 16'h00DD));
      chk("lb_rx_ring", 32'(rx), 32'(pk(2'd1, 2'd2, 16'h00DD)));
      chk("lb_ro_idle1", 32'(ring_out), 0);
      step('0, '0);
      chk("lb_rx_local", 32'(rx), 32'(pk(2'd1, 2'd0, 16'h0C0C)));
      chk("lb_ro_idle2", 32'(ring_out), 0);
      for (int i = 0; i < 305; i++) step(pk(2'd2, 2'd1, 16'(i)), pk(2'd3, 2'd0, 16'hEEEE));
      chk("drop_sat", 32'(drop_cnt), 255);
      for (int i = 0; i < 6; i++) step('0, '0);
      for (int ph = 0; ph < 4; ph++) begin
         p = ph * 30;
         for (int i = 0; i < 500; i++) begin
            a = $urandom;
            b = $urandom;
            step({1'($urandom_range(99) < 60), a[PW-2:0]},
                 {1'($urandom_range(99) < p), b[PW-2:0]});
         end
      end
      step(pk(2'd0, 2'd1, 16'h4242), pk(2'd1, 2'd3, 16'h2424));
      step(pk(2'd0, 2'd1, 16'h4343), '0);
      @(posedge clk);
      #2;
      chk_en = 0;
      rst = 0;
      #1;
      chk("async_rst_ro", 32'(ring_out), 0);
      chk("async_rst_rx", 32'(rx), 0);
      chk("async_rst_cnt", 32'(fifo_cnt), 0);
      chk("async_rst_drop", 32'(drop_cnt), 0);
      model_clear();
      tx = '0;
      ring_in = '0;
      @(posedge clk);
      #1;
      chk_en = 1;
      rst = 1;
      step('0, pk(2'd3, 2'd1, 16'h9999));
      step('0, '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
